serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/fa_bit_cell.sv | 17 +
 rtl/serial_add_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding
// and the default operand width.
package serial_add_pkg;

  localparam int SERIAL_ADD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder, time-shared by serial_add_ctrl.
// Ports: x, y, ci in; s (sum bit), co (carry out).
module fa_bit_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell over WIDTH cycles, LSB first.
// Ports: clk, rst (async high), start, a, b, cin -> busy, done, sum, cout.
// Build macro SERIAL_ADD_SUB_EN adds input sub (a + ~b + 1, cin ignored).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Subtraction is a + ~b + 1: invert B and force carry-in.
`ifdef SERIAL_ADD_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  fa_bit_cell u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b_in;
          c_d     = c_in;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      RUN: begin
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        c_d   = fa_co;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Counter stops at LAST; the FSM leaves RUN before it can wrap.
        if (cnt_q == LAST) begin
          state_d = DONE;
          cout_d  = fa_co;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Expected results queued at issue; a monitor pops them on done.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];
  int done_cyc[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0h required=none",
                 {cout, sum});
      end else begin
        chk("result", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // Caller is at a negedge. Issues one op and checks latency.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic [W:0] ex);
    start = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    chk("busy_after_accept", 32'(busy), 1);
    start = 1'b0;
    a = ~ta;
    b = ~tb;
    cin = ~tc;
    repeat (W - 1) @(posedge clk);
    #1;
    chk("done_early", 32'(done), 0);
    @(posedge clk);
    #1;
    chk("done_at_W", 32'(done), 1);
    chk("busy_at_W", 32'(busy), 1);
    @(posedge clk);
    #1;
    chk("done_len", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    int dc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    @(negedge clk);
    rst = 1'b0;

    issue(8'h0F, 8'h01, 1'b0, {1'b0, 8'h10});
    issue(8'hFF, 8'h01, 1'b0, {1'b1, 8'h00});
    issue(8'h00, 8'h00, 1'b1, {1'b0, 8'h01});

    // Restarts during RUN and DONE must be ignored
    dc = done_cnt;
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    exp_q.push_back({1'b0, 8'h46});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    a = 8'hC3;
    b = 8'h77;
    cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    chk("busy_edge8", 32'(busy), 1);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_edge9", 32'(busy), 0);
    repeat (12) @(posedge clk);
    #1;
    chk("ignored_starts", 32'(done_cnt - dc), 1);
    chk("idle_hold_sum", 32'(sum), 32'h46);

    // Reset in the middle of RUN
    @(negedge clk);
    dc = done_cnt;
    start = 1'b1;
    a = 8'h55;
    b = 8'h22;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    issue(8'h7F, 8'h01, 1'b1, {1'b0, 8'h81});
    chk("abort_no_done", 32'(done_cnt - dc), 1);

    // Back-to-back with start held high
    done_cyc.delete();
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      unique case (k)
        0: begin a = 8'h80; b = 8'h80; cin = 1'b0;
             exp_q.push_back({1'b1, 8'h00}); end
        1: begin a = 8'hAA; b = 8'h55; cin = 1'b1;
             exp_q.push_back({1'b1, 8'h00}); end
        default: begin a = 8'h3C; b = 8'h0F; cin = 1'b1;
             exp_q.push_back({1'b0, 8'h4C}); end
      endcase
      @(posedge clk);
      repeat (W + 1) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    chk("b2b_count", 32'(done_cyc.size()), 3);
    if (done_cyc.size() == 3) begin
      chk("b2b_gap1", 32'(done_cyc[1] - done_cyc[0]), W + 2);
      chk("b2b_gap2", 32'(done_cyc[2] - done_cyc[1]), W + 2);
    end

`ifdef SERIAL_ADD_SUB_EN
    @(negedge clk);
    sub = 1'b1;
    issue(8'h05, 8'h07, 1'b0, {1'b0, 8'hFE});
    sub = 1'b1;
    issue(8'h07, 8'h05, 1'b1, {1'b1, 8'h02});
    sub = 1'b0;
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
